// File: rtl/yrv_seg7_scan.sv
// yrv_seg7_scan: multiplexed 4-digit 7-segment driver with per-frame snapshot,
// leading-zero suppression and an anti-ghosting blank gap at each slot start.
module yrv_seg7_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] port0_reg,
    input  logic [15:0] port1_reg,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);
    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_snap0;
    logic [8:0]    r_snap1;
    logic          r_pend;

    logic          w_wrap;
    logic          w_load;
    logic          w_sup;
    logic          w_lit;
    logic [3:0]    w_nib;
    logic [3:0]    w_blank;
    logic [3:0]    w_an;
    logic [6:0]    w_glyph;

    assign w_wrap  = r_cnt == CW'(SCAN_DIV - 1);
    assign w_load  = r_pend | (w_wrap & (r_idx == 2'd3));
    assign w_nib   = r_snap0[{r_idx, 2'b00} +: 4];
    assign w_blank = r_snap1[7:4];
    assign w_an    = 4'b0001 << r_idx;
    // A digit is suppressed when it and every digit to its left are zero
    assign w_sup   = r_snap1[8] & (r_idx != 2'd0) & ((r_snap0 >> {r_idx, 2'b00}) == 16'h0);
    assign w_lit   = (r_cnt >= CW'(BLANK_CYC)) & ~w_blank[r_idx] & ~w_sup;

    always_comb begin
        w_glyph = 7'h00;
        case (w_nib)
            4'h0: w_glyph = 7'h3F;
            4'h1: w_glyph = 7'h06;
            4'h2: w_glyph = 7'h5B;
            4'h3: w_glyph = 7'h4F;
            4'h4: w_glyph = 7'h66;
            4'h5: w_glyph = 7'h6D;
            4'h6: w_glyph = 7'h7D;
            4'h7: w_glyph = 7'h07;
            4'h8: w_glyph = 7'h7F;
            4'h9: w_glyph = 7'h6F;
            4'hA: w_glyph = 7'h77;
            4'hB: w_glyph = 7'h7C;
            4'hC: w_glyph = 7'h39;
            4'hD: w_glyph = 7'h5E;
            4'hE: w_glyph = 7'h79;
            default: w_glyph = 7'h71;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_idx      <= 2'd0;
            r_snap0    <= 16'h0;
            r_snap1    <= 9'h0;
            r_pend     <= 1'b1;
            seg        <= {7{SEG_ACTIVE_LOW}};
            dp         <= SEG_ACTIVE_LOW;
            an         <= {4{AN_ACTIVE_LOW}};
            frame_tick <= 1'b0;
        end else begin
            r_cnt      <= w_wrap ? '0 : r_cnt + 1'b1;
            r_idx      <= w_wrap ? r_idx + 2'd1 : r_idx;
            r_pend     <= 1'b0;
            if (w_load) begin
                r_snap0 <= port0_reg;
                r_snap1 <= port1_reg[8:0];
            end
            frame_tick <= w_load;
            seg        <= (w_lit ? w_glyph : 7'h00) ^ {7{SEG_ACTIVE_LOW}};
            dp         <= (w_lit & r_snap1[r_idx]) ^ SEG_ACTIVE_LOW;
            an         <= (w_lit ? w_an : 4'h0) ^ {4{AN_ACTIVE_LOW}};
        end
    end
endmodule
